// File: rtl/exec_ctrl.sv
// Four-state instruction sequencer: accepts one instruction, reads operands, latches ALU
// results into the register file and flags, and pulses done. Fetch/execute throughput is 1 per 4 cycles.
module exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        flag_z,
  output logic        flag_c,
  output logic        done,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [7:0]  regs_q [8];
  // {opcode[12:10], rd[9:7], rs_a[6:4], rs_b[3:1], wb_en[0]}
  logic [12:0] instr_q;
  logic        accept, ld_ok, rd_stage, ex_stage;
  logic        unused_bits;

  assign unused_bits = ^instr[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid && instr_ready) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = rst_n && (state_q == IDLE);
    accept      = instr_ready && instr_valid;
    ld_ok       = (state_q == IDLE) && ld_en;
    rd_stage    = (state_q == READ);
    ex_stage    = (state_q == EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (accept) instr_q <= instr[15:3];
      if (rd_stage) begin
        alu_a      <= regs_q[instr_q[6:4]];
        alu_b      <= regs_q[instr_q[3:1]];
        alu_opcode <= instr_q[12:10];
      end
      done <= ex_stage;
      if (ex_stage) begin
        flag_z <= alu_zero;
        // carry is architecturally meaningful only for add/sub
        if (instr_q[12:11] == 2'b00) flag_c <= alu_carry;
      end
    end
  end

  // Preload only in IDLE and writeback only in EXEC, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      if (ld_ok) regs_q[ld_addr] <= ld_data;
      if (ex_stage && instr_q[0]) regs_q[instr_q[9:7]] <= alu_out;
    end
  end

  assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: behavioural ALU on the ALU ports, register-file/flag reference model,
// directed scenarios followed by randomized instructions and preloads.
module tb_exec_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_valid = 1'b0, instr_ready;
  logic [15:0] instr = '0;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_opcode;
  logic        alu_zero, alu_carry, flag_z, flag_c, done;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0, dbg_addr = '0;
  logic [7:0]  ld_data = '0, dbg_data;

  int passed = 0, total = 0;
  logic [7:0] m_r [8];
  logic       m_z, m_c;

  exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .flag_z(flag_z), .flag_c(flag_c), .done(done),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU: 0 ADD, 1 SUB (carry=borrow), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASS; returns {c,z,r}
  function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = a;
    endcase
    return {c, (r == 8'd0), r};
  endfunction

  assign {alu_carry, alu_zero, alu_out} = alu_f(alu_opcode, alu_a, alu_b);

  function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb, input int wb);
    return {3'(op), 3'(rd), 3'(ra), 3'(rb), 1'(wb), 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk(tag, dbg_data, m_r[i]);
    end
  endtask

  task automatic idle_load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_r[a] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_z = 1'b0; m_c = 1'b0;
  endtask

  // ld: preload on the accepting edge; keep: hold valid and present nxt right after accept;
  // xld: preload attempt during EXEC/WB, which must be ignored
  task automatic run_instr(input logic [15:0] ins, input bit ld, input logic [2:0] la, input logic [7:0] ldd,
                           input bit keep, input logic [15:0] nxt,
                           input bit xld, input logic [2:0] xa, input logic [7:0] xd);
    int n;
    logic [2:0] op, rd, ra, rb;
    logic       wb;
    logic [9:0] res;
    op = ins[15:13]; rd = ins[12:10]; ra = ins[9:7]; rb = ins[6:4]; wb = ins[3];
    n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    chk("ready_wait", instr_ready, 1'b1);
    instr_valid = 1'b1; instr = ins; ld_en = ld; ld_addr = la; ld_data = ldd;
    @(posedge clk); #1;
    if (ld) m_r[la] = ldd;
    ld_en = 1'b0;
    if (keep) instr = nxt; else instr_valid = 1'b0;
    chk("ready_T", instr_ready, 1'b0);
    chk("done_T", done, 1'b0);
    @(posedge clk); #1;
    chk("alu_a", alu_a, m_r[ra]);
    chk("alu_b", alu_b, m_r[rb]);
    chk("alu_op", alu_opcode, op);
    chk("done_T1", done, 1'b0);
    res = alu_f(op, m_r[ra], m_r[rb]);
    if (xld) begin ld_en = 1'b1; ld_addr = xa; ld_data = xd; end
    @(posedge clk); #1;
    if (wb) m_r[rd] = res[7:0];
    m_z = res[8];
    if (op <= 3'd1) m_c = res[9];
    chk("done_T2", done, 1'b1);
    chk("flag_z", flag_z, m_z);
    chk("flag_c", flag_c, m_c);
    dbg_addr = rd;
    #1 chk("rd_val", dbg_data, m_r[rd]);
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (xld) begin dbg_addr = xa; #1 chk("xld_ignored", dbg_data, m_r[xa]); end
    chk("done_T3", done, 1'b0);
    chk("ready_T3", instr_ready, 1'b1);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {flag_z, flag_c}, 2'b00);
    chk("rst_alu", {alu_a, alu_b, 5'(alu_opcode)}, 21'h0);
    sweep("rst_reg");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 0x0F+0x01
    idle_load(3'd1, 8'h0F); idle_load(3'd2, 8'h01);
    run_instr(mk(0, 3, 1, 2, 1), 0, 0, 0, 0, 0, 0, 0, 0);
    // carry/zero ADD, then SUB with borrow
    idle_load(3'd1, 8'hFF); idle_load(3'd2, 8'h01);
    run_instr(mk(0, 4, 1, 2, 1), 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(mk(1, 5, 2, 1, 1), 0, 0, 0, 0, 0, 0, 0, 0);
    // compare-only XOR keeps carry and R6
    run_instr(mk(4, 6, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
    // held valid: back-to-back accepts 4 cycles apart; preload during EXEC ignored
    run_instr(mk(3, 2, 4, 5, 1), 0, 0, 0, 1, mk(2, 6, 1, 5, 1), 0, 0, 0);
    run_instr(mk(2, 6, 1, 5, 1), 0, 0, 0, 0, 0, 1, 3'd3, 8'hEE);
    // preload on the accepting edge feeds the read
    run_instr(mk(5, 0, 7, 7, 1), 1, 3'd7, 8'h55, 0, 0, 0, 0, 0);
    sweep("dir_regs");

    // reset mid-instruction
    instr_valid = 1'b1; instr = mk(0, 1, 7, 7, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_ready", instr_ready, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_flags", {flag_z, flag_c}, 2'b00);
    sweep("mrst_reg");
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("mrst_ready_rel", instr_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_done", done, 1'b0);
    end
    sweep("mrst_reg2");
    run_instr(mk(0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ins;
      bit ld, xld;
      ins = 16'($urandom_range(0, 65535));
      ld  = ($urandom_range(0, 2) == 0);
      xld = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) idle_load(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      run_instr(ins, ld, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 0, 0,
                xld, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    sweep("final_regs");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
